// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   - register offsets, as word indices taken from a[3:2]
//   - bit positions inside the STATUS register
//   - transmitter FSM state type
package mmio_uart_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_BUSY     = 2;
    localparam int ST_OVERFLOW = 3;
    localparam int ST_COUNT_LO = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and a combinational
// read port showing the head entry.
// Ports:
//   clk, reset  clock and synchronous active-high reset (pointers and count only)
//   push, wdata write request and data; accepted when not full, or when
//               a pop happens on the same edge
//   pop         removes the head entry; ignored when empty
//   rdata       head entry (valid while !empty)
//   full, empty, count  occupancy status
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        // A push into a full FIFO is still fine when the head leaves on the same edge.
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter sitting beside dmem on the
// core's data-memory port.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   we, a, wd   store strobe, byte address, store data (MemWrite/DataAdr/WriteData)
//   rd          combinational read data of the addressed register (0 when !hit)
//   hit         a falls inside the 16-byte register window at BASE_ADDR
//   txd         registered serial output, idle high
//   irq         registered, high when the FIFO is empty and the FSM idle
// Registers (a[3:2]): 0 TXDATA (W push), 1 STATUS (R status / W clear overflow),
//   2 BAUDDIV (R/W divider, bit period = div+1 clocks), 3 reserved.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0080,
    parameter int          DEPTH       = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        txd,
    output logic        irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    uart_state_t state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] div_lat_q, div_lat_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        ovf_q, ovf_d;
    logic        txd_q, txd_d;
    logic        irq_q, irq_d;

    logic [1:0]    off;
    logic          wr_en;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_nx;
    logic [31:0]   status;
    logic          unused_bits;

    assign hit      = (a[31:4] == BASE_ADDR[31:4]);
    assign off      = a[3:2];
    assign wr_en    = we && hit;
    assign push_req = wr_en && (off == OFF_TXDATA);

    assign unused_bits = ^{a[1:0], wd[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .wdata (wd[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        div_lat_d = div_lat_q;
        div_d     = div_q;
        ovf_d     = ovf_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_rdata;
                    // The divider is frozen for the whole frame.
                    div_lat_d = div_q;
                    cnt_d     = '0;
                    bit_d     = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (cnt_q == div_lat_q) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == div_lat_q) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == div_lat_q) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_en && (off == OFF_BAUDDIV)) begin
            div_d = wd[15:0];
        end
        if (wr_en && (off == OFF_STATUS)) begin
            ovf_d = 1'b0;
        end
        push_ok = push_req && (!fifo_full || pop);
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end

        // txd and irq are registered, so they are derived from the next state.
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        count_nx = fifo_count + CW'(push_ok) - CW'(pop);
        irq_d    = (state_d == S_IDLE) && (count_nx == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            div_q   <= DEFAULT_DIV;
            ovf_q   <= 1'b0;
            txd_q   <= 1'b1;
            irq_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
            txd_q   <= txd_d;
            irq_q   <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q   <= shift_d;
        div_lat_q <= div_lat_d;
    end

    assign txd = txd_q;
    assign irq = irq_q;

    always_comb begin
        status                          = '0;
        status[ST_EMPTY]                = fifo_empty;
        status[ST_FULL]                 = fifo_full;
        status[ST_BUSY]                 = (state_q != S_IDLE);
        status[ST_OVERFLOW]             = ovf_q;
        status[ST_COUNT_LO +: 8]        = 8'(fifo_count);
    end

    always_comb begin
        rd = '0;
        if (hit) begin
            case (off)
                OFF_STATUS:  rd = status;
                OFF_BAUDDIV: rd = {16'b0, div_q};
                default:     rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: bus-driven bench for mmio_uart_tx. Each accepted byte's
// expected frame (data, bit period, back-to-back flag) goes into a queue; a
// serial monitor decodes txd and checks every bit cycle against the head entry.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE   = 32'h0000_0080;
    localparam logic [31:0] A_TX   = BASE + 32'h0;
    localparam logic [31:0] A_ST   = BASE + 32'h4;
    localparam logic [31:0] A_DIV  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;
    logic        txd;
    logic        irq;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         b2b;
    } frame_t;

    frame_t exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     mon_en  = 1'b0;
    bit     mon_active = 1'b0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .DEPTH       (4),
        .DEFAULT_DIV (16'd15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .hit   (hit),
        .txd   (txd),
        .irq   (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        a  = addr;
        wd = data;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] v);
        we = 1'b0;
        a  = addr;
        #1;
        v = rd;
    endtask

    task automatic expect_frame(input logic [7:0] data, input int div, input bit b2b);
        frame_t f;
        f.data = data;
        f.div  = div;
        f.b2b  = b2b;
        exp_q.push_back(f);
    endtask

    task automatic wait_drain(input string tag, input int limit);
        logic [31:0] v;
        bit ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk);
            #1;
            bus_rd(A_ST, v);
            if (exp_q.size() == 0 && !mon_active && v == 32'h1) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    // Serial monitor: start bit detected at a negedge sample, then every cycle
    // of the ten bits is compared with the expected level.
    initial begin : monitor
        int         gap;
        int         nf;
        frame_t     e;
        logic [9:0] bits;
        gap = 0;
        nf  = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                gap = 0;
                continue;
            end
            if (txd === 1'b1) begin
                gap++;
                continue;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
                gap = 0;
                continue;
            end
            mon_active = 1'b1;
            e = exp_q.pop_front();
            if (e.b2b) check($sformatf("frame%0d_gap", nf), gap, 1);
            bits = {1'b1, e.data, 1'b0};
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c <= e.div; c++) begin
                    if (b != 0 || c != 0) begin
                        @(negedge clk);
                        check($sformatf("frame%0d_bit%0d_cyc%0d", nf, b, c), 32'(txd), 32'(bits[b]));
                    end
                end
            end
            nf++;
            gap = 0;
            mon_active = 1'b0;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] v;
        logic [7:0]  t3 [6];
        int          n;
        t3[0] = 8'h11; t3[1] = 8'hA5; t3[2] = 8'h3C;
        t3[3] = 8'hF0; t3[4] = 8'h81; t3[5] = 8'h77;

        reset = 1'b1;
        we    = 1'b0;
        a     = 32'h0;
        wd    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and decode
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq", 32'(irq), 32'd1);
        bus_rd(A_ST, v);   check("rst_status", v, 32'h0000_0001);
        bus_rd(A_DIV, v);  check("rst_bauddiv", v, 32'h0000_000F);
        check("hit_in", 32'(hit), 32'd1);
        bus_rd(32'h0000_0090, v);
        check("hit_out", 32'(hit), 32'd0);
        check("rd_out", v, 32'h0);
        bus_wr(A_RSV, 32'hFFFF_FFFF);
        bus_rd(A_RSV, v);  check("rd_rsv", v, 32'h0);
        bus_rd(A_TX, v);   check("rd_txdata", v, 32'h0);
        bus_rd(A_ST, v);   check("rsv_wr_noeffect", v, 32'h0000_0001);
        mon_en = 1'b1;

        // Single frame, div=1
        bus_wr(A_DIV, 32'h0000_0001);
        expect_frame(8'h55, 1, 1'b0);
        bus_wr(A_TX, 32'h0000_0055);
        check("t2_txd_edge0", 32'(txd), 32'd1);
        @(posedge clk);
        #1;
        check("t2_txd_edge1", 32'(txd), 32'd0);
        check("t2_irq_busy", 32'(irq), 32'd0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            bus_rd(A_ST, v);
            if (v[2]) n++;
            else break;
            @(posedge clk);
            #1;
        end
        check("t2_busy_cycles", n, 20);
        check("t2_irq_done", 32'(irq), 32'd1);
        wait_drain("t2_drain", 100);

        // Overflow with DIV=15 and six consecutive pushes
        bus_wr(A_DIV, 32'h0000_000F);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) expect_frame(t3[i], 15, i > 0);
            bus_wr(A_TX, {24'h0, t3[i]});
        end
        bus_rd(A_ST, v);   check("t3_status", v, 32'h0000_040E);

        // Clear overflow, FIFO untouched, then everything drains in order
        bus_wr(A_ST, 32'h0);
        bus_rd(A_ST, v);   check("t4_status", v, 32'h0000_0406);
        wait_drain("t4_drain", 2000);

        // Divider change mid-frame only affects the next frame
        bus_wr(A_DIV, 32'h0000_0001);
        expect_frame(8'hA3, 1, 1'b0);
        bus_wr(A_TX, 32'h0000_00A3);
        expect_frame(8'h3C, 3, 1'b1);
        bus_wr(A_TX, 32'h0000_003C);
        repeat (3) @(posedge clk);
        #1;
        bus_wr(A_DIV, 32'h0000_0003);
        bus_rd(A_DIV, v);  check("t5_bauddiv", v, 32'h0000_0003);
        wait_drain("t5_drain", 300);

        // Reset in the middle of a frame discards everything
        mon_en = 1'b0;
        bus_wr(A_DIV, 32'h0000_0001);
        bus_wr(A_TX, 32'h0000_000F);
        bus_wr(A_TX, 32'h0000_0081);
        repeat (4) @(posedge clk);
        #1;
        bus_rd(A_ST, v);   check("t6_busy_before", 32'(v[2]), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6_txd", 32'(txd), 32'd1);
        check("t6_irq", 32'(irq), 32'd1);
        bus_rd(A_ST, v);   check("t6_status", v, 32'h0000_0001);
        bus_rd(A_DIV, v);  check("t6_bauddiv", v, 32'h0000_000F);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) n++;
        end
        check("t6_no_frame", n, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
